// File: rtl/rgmii_pkg.sv
// Shared types and constants for the RGMII/UDP transmit path.
// The transmit arbiter's optional stall abort is enabled by PACKET_ARB_TIMEOUT_EN.
package rgmii_pkg;

  // Transmit arbiter frame-level states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2,
    GAP   = 2'd3
  } arb_state_t;

  // Ethernet inter-frame gap, in byte times; one byte per clock on this path.
  localparam int IFG_BYTES = 12;

endpackage

// File: rtl/axis_if.sv
// AXI-Stream link between the transmit arbiter and the packet builder.
//
// Handshake: a beat transfers on a rising clock edge where tvalid and tready
// are both high. Once the master raises tvalid it holds tvalid, tdata and
// tlast stable until that transfer; tready may change freely; tlast marks the
// final beat of a frame.
interface axis_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester after last_i wins,
// wrapping modulo N. Reports both a one-hot and an encoded grant.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] last_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 valid_o
);

  logic [$clog2(N)-1:0] cand;

  // Walk the requesters starting just after the previous winner.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int i = 1; i <= N; i++) begin
      cand = $clog2(N)'((int'(last_i) + i) % N);
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/packet_tx_arbiter.sv
// Frame-level round-robin scheduler sharing one transmit datapath between
// N_SRC AXI-Stream payload sources. Holds a grant for a whole frame, clamps
// the frame to the configured length and enforces an inter-frame gap.
// Optional stall abort: define PACKET_ARB_TIMEOUT_EN.
module packet_tx_arbiter
  import rgmii_pkg::*;
#(
  parameter int N_SRC           = 4,
  parameter int AXIS_DATA_WIDTH = 8,
  parameter int PAYLOAD_WIDTH   = 11,
  parameter int GAP_CYCLES      = IFG_BYTES,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [N_SRC-1:0]                   s_tvalid_i,
  input  logic [N_SRC*AXIS_DATA_WIDTH-1:0]   s_tdata_i,
  input  logic [N_SRC-1:0]                   s_tlast_i,
  output logic [N_SRC-1:0]                   s_tready_o,
  input  logic [N_SRC*PAYLOAD_WIDTH-1:0]     payload_bytes_i,
  axis_if.master                             m_axis,
  output logic [PAYLOAD_WIDTH-1:0]           payload_bytes_o,
  output logic [$clog2(N_SRC)-1:0]           grant_o,
  output logic                               busy_o,
  output logic                               len_err_o,
  output logic                               timeout_o,
  output arb_state_t                         state_o
);

  localparam int IW = $clog2(N_SRC);
  localparam int W  = AXIS_DATA_WIDTH;
  localparam int PW = PAYLOAD_WIDTH;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  // With no gap configured a finished frame returns straight to IDLE.
  localparam arb_state_t END_STATE = (GAP_CYCLES == 0) ? IDLE : GAP;

  arb_state_t    state_q, state_d;
  logic [IW-1:0] grant_q, grant_d, last_grant_q, last_grant_d;
  logic [PW-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;

  logic [N_SRC-1:0] req, rr_gnt;
  logic [IW-1:0]    rr_idx;
  logic             rr_valid;
  logic [PW-1:0]    sel_len;
  logic             src_valid, src_last;
  logic [W-1:0]     src_data;
  logic             cnt_last, ready_g, abort;
  logic             m_tvalid, m_tlast;
  logic [W-1:0]     m_tdata;

  // Eligibility masks out sources configured with a zero-length frame.
  always_comb begin
    req     = '0;
    sel_len = '0;
    for (int k = 0; k < N_SRC; k++) begin
      req[k] = s_tvalid_i[k] && (payload_bytes_i[k*PW +: PW] != '0);
      if (rr_gnt[k]) sel_len = payload_bytes_i[k*PW +: PW];
    end
  end

  rr_arbiter #(.N(N_SRC)) u_rr (
    .req_i   (req),
    .last_i  (last_grant_q),
    .gnt_o   (rr_gnt),
    .idx_o   (rr_idx),
    .valid_o (rr_valid)
  );

  // Select the granted source's stream signals.
  always_comb begin
    src_valid = 1'b0;
    src_last  = 1'b0;
    src_data  = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (grant_q == IW'(k)) begin
        src_valid = s_tvalid_i[k];
        src_last  = s_tlast_i[k];
        src_data  = s_tdata_i[k*W +: W];
      end
    end
  end

  assign cnt_last = (cnt_q == len_q - PW'(1));

`ifdef PACKET_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] stall_q, stall_d;

  assign abort = (state_q == XFER) && (stall_q == TW'(TIMEOUT_CYCLES));

  // Count consecutive idle source cycles in XFER; freeze once the abort beat is up.
  always_comb begin
    stall_d = stall_q;
    if (state_q != XFER || (src_valid && !abort)) stall_d = '0;
    else if (!abort)                              stall_d = stall_q + TW'(1);
  end

  // Stall counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) stall_q <= '0;
    else       stall_q <= stall_d;
  end
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT_CYCLES != 0);
  assign abort          = 1'b0;
`endif

  // Next-state, counters and the combinational datapath/handshake outputs.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    gap_d        = gap_q;
    m_tvalid     = 1'b0;
    m_tdata      = '0;
    m_tlast      = 1'b0;
    ready_g      = 1'b0;
    len_err_o    = 1'b0;
    timeout_o    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rr_valid) begin
          state_d      = XFER;
          grant_d      = rr_idx;
          last_grant_d = rr_idx;
          len_d        = sel_len;
          cnt_d        = '0;
        end
      end
      XFER: begin
        if (abort) begin
          // Synthetic terminating beat; the source is not consumed.
          m_tvalid = 1'b1;
          m_tlast  = 1'b1;
          if (m_axis.tready) begin
            timeout_o = 1'b1;
            gap_d     = '0;
            state_d   = END_STATE;
          end
        end else begin
          m_tvalid = src_valid;
          m_tdata  = src_data;
          m_tlast  = src_last || cnt_last;
          ready_g  = m_axis.tready;
          if (src_valid && m_axis.tready) begin
            cnt_d = cnt_q + PW'(1);
            if (m_tlast) begin
              len_err_o = src_last ^ cnt_last;
              gap_d     = '0;
              // Counter ended the frame before the source did: discard the rest.
              state_d   = (cnt_last && !src_last) ? DRAIN : END_STATE;
            end
          end
        end
      end
      DRAIN: begin
        ready_g = 1'b1;
        if (src_valid && src_last) begin
          gap_d   = '0;
          state_d = END_STATE;
        end
      end
      GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) state_d = IDLE;
        else                              gap_d   = gap_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Only the granted source ever sees ready.
  always_comb begin
    s_tready_o = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (grant_q == IW'(k)) s_tready_o[k] = ready_g;
    end
  end

  // State, grant and counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IW'(N_SRC - 1);
      len_q        <= '0;
      cnt_q        <= '0;
      gap_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
    end
  end

  assign m_axis.tvalid   = m_tvalid;
  assign m_axis.tdata    = m_tdata;
  assign m_axis.tlast    = m_tlast;
  assign payload_bytes_o = len_q;
  assign grant_o         = grant_q;
  assign busy_o          = (state_q != IDLE);
  assign state_o         = state_q;

endmodule

// File: tb/tb_packet_tx_arbiter.sv
// Self-checking bench for packet_tx_arbiter. Per-source frames are queued,
// a frame-level round-robin model predicts the output beat stream, and a
// monitor compares every output handshake against it.
// Build with PACKET_ARB_TIMEOUT_EN defined to also exercise the stall abort.
module tb_packet_tx_arbiter;
  import rgmii_pkg::*;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int PW  = 11;
  localparam int GAP = 12;
`ifdef PACKET_ARB_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 1024;
`endif
  localparam int IW = $clog2(N);
  localparam int EW = 1 + IW + W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic [N-1:0]    s_tvalid, s_tlast, s_tready;
  logic [N*W-1:0]  s_tdata;
  logic [N*PW-1:0] pbytes;
  logic [PW-1:0]   pb_o;
  logic [IW-1:0]   grant;
  logic            busy, lerr, tmo;
  arb_state_t      st;

  axis_if #(.DATA_WIDTH(W)) m_axis ();

  packet_tx_arbiter #(
    .N_SRC(N), .AXIS_DATA_WIDTH(W), .PAYLOAD_WIDTH(PW),
    .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .s_tvalid_i(s_tvalid), .s_tdata_i(s_tdata), .s_tlast_i(s_tlast),
    .s_tready_o(s_tready), .payload_bytes_i(pbytes), .m_axis(m_axis),
    .payload_bytes_o(pb_o), .grant_o(grant), .busy_o(busy),
    .len_err_o(lerr), .timeout_o(tmo), .state_o(st)
  );

  // ---------------- stimulus state ----------------
  logic [W-1:0] sd [N][$];   // beats still to be offered per source
  bit           sl [N][$];
  bit           sf [N][$];   // first beat of a source frame
  logic [W-1:0] mb [N][$];   // model copy of the bytes
  int           mfl[N][$];   // model copy of the frame lengths
  int           cfg_len[N];
  bit           hold[N];
  int           rdy_pct   = 100;
  int           stall_pct = 0;
  bit           strict_gap = 1'b0;

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int vectors = 0, miscompares = 0;
  int lerr_cnt = 0, to_cnt = 0, exp_lerr = 0, exp_to = 0, beats = 0;
  bit in_frame = 1'b0, have_prev = 1'b0;
  int last_end = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  // Monitor: compare each output handshake against the head of the queue.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst) begin
      in_frame  = 1'b0;
      have_prev = 1'b0;
    end else begin
      if (lerr) lerr_cnt++;
      if (tmo)  to_cnt++;
      if (m_axis.tvalid && m_axis.tready) begin
        beats++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_beat: got data %0h grant %0d, expected no beat", m_axis.tdata, grant);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data",  32'(m_axis.tdata), 32'(e[W-1:0]));
          chk("beat_last",  32'(m_axis.tlast), 32'(e[EW-1]));
          chk("beat_grant", 32'(grant),        32'(e[W +: IW]));
          chk("beat_len",   32'(pb_o),         32'(cfg_len[e[W +: IW]]));
        end
        if (!in_frame) begin
          if (have_prev) begin
            if (strict_gap) chk("frame_gap", 32'(cyc - last_end), 32'(GAP + 2));
            else            chk("frame_gap_min", {31'b0, (cyc - last_end >= GAP + 2)}, 32'd1);
          end
          in_frame = 1'b1;
        end
        if (m_axis.tlast) begin
          in_frame  = 1'b0;
          have_prev = 1'b1;
          last_end  = cyc;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One clock: sample source handshakes mid-cycle, then drive new inputs after the edge.
  task automatic step();
    bit hs [N];
    @(negedge clk);
    for (int k = 0; k < N; k++) hs[k] = s_tvalid[k] && s_tready[k];
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (hs[k] && sd[k].size() != 0) begin
        void'(sd[k].pop_front());
        void'(sl[k].pop_front());
        void'(sf[k].pop_front());
      end
      if (sd[k].size() == 0) begin
        s_tvalid[k] = 1'b0;
        s_tlast[k]  = 1'b0;
        s_tdata[k*W +: W] = '0;
      end else begin
        s_tdata[k*W +: W] = sd[k][0];
        s_tlast[k]        = sl[k][0];
        if (s_tvalid[k] && !hs[k]) s_tvalid[k] = 1'b1;
        else if (sf[k][0])          s_tvalid[k] = 1'b1;
        else if (hold[k])           s_tvalid[k] = 1'b0;
        else                        s_tvalid[k] = ($urandom_range(0, 99) >= stall_pct);
      end
    end
    m_axis.tready = ($urandom_range(0, 99) < rdy_pct);
  endtask

  task automatic set_cfg();
    for (int k = 0; k < N; k++) pbytes[k*PW +: PW] = PW'(cfg_len[k]);
  endtask

  task automatic add_frame(input int k, input int fl);
    logic [W-1:0] b;
    for (int j = 0; j < fl; j++) begin
      b = W'($urandom);
      sd[k].push_back(b);
      sl[k].push_back(j == fl - 1);
      sf[k].push_back(j == 0);
      mb[k].push_back(b);
    end
    mfl[k].push_back(fl);
  endtask

  // Reference model: frames are served whole, round-robin from source 0,
  // skipping zero-length sources; each frame is cut at the configured length.
  task automatic plan();
    int last, found, c, fl, n;
    logic [W-1:0] b;
    last = N - 1;
    while (1) begin
      found = -1;
      for (int i = 1; i <= N; i++) begin
        c = (last + i) % N;
        if (found < 0 && cfg_len[c] != 0 && mfl[c].size() != 0) found = c;
      end
      if (found < 0) break;
      fl = mfl[found].pop_front();
      n  = (fl < cfg_len[found]) ? fl : cfg_len[found];
      for (int j = 0; j < fl; j++) begin
        b = mb[found].pop_front();
        if (j < n) exp_q.push_back({(j == n - 1), IW'(found), b});
      end
      if (fl != cfg_len[found]) exp_lerr++;
      last = found;
    end
  endtask

  function automatic int pending();
    int p = 0;
    for (int k = 0; k < N; k++)
      if (cfg_len[k] != 0 && !hold[k]) p += sd[k].size();
    return p;
  endfunction

  task automatic flush();
    for (int k = 0; k < N; k++) begin
      sd[k].delete(); sl[k].delete(); sf[k].delete();
      mb[k].delete(); mfl[k].delete();
      cfg_len[k] = 0;
      hold[k]    = 1'b0;
    end
    exp_q.delete();
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    set_cfg();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_tvalid"},  32'(m_axis.tvalid), 32'd0);
    chk({tag, "_tlast"},   32'(m_axis.tlast),  32'd0);
    chk({tag, "_tdata"},   32'(m_axis.tdata),  32'd0);
    chk({tag, "_s_tready"},32'(s_tready),      32'd0);
    chk({tag, "_grant"},   32'(grant),         32'd0);
    chk({tag, "_payload"}, 32'(pb_o),          32'd0);
    chk({tag, "_busy"},    32'(busy),          32'd0);
    chk({tag, "_len_err"}, 32'(lerr),          32'd0);
    chk({tag, "_timeout"}, 32'(tmo),           32'd0);
    chk({tag, "_state"},   32'(st),            32'(IDLE));
  endtask

  task automatic clear_counts();
    lerr_cnt = 0; to_cnt = 0; exp_lerr = 0; exp_to = 0; beats = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    flush();
    step();
    chk_reset("reset");
    rst = 1'b0;
    clear_counts();
  endtask

  // Run until every predicted beat and source beat is consumed, then idle a while.
  task automatic run(input string nm, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || pending() != 0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_stuck: got %0d beats outstanding, expected 0", nm, exp_q.size() + pending());
      exp_q.delete();
    end
    repeat (GAP + 6) step();
    chk({nm, "_len_err_count"}, 32'(lerr_cnt), 32'(exp_lerr));
    chk({nm, "_timeout_count"}, 32'(to_cnt),   32'(exp_to));
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int masked, mcount, nf, n;
    m_axis.tready = 1'b0;
    flush();
    clear_counts();
    do_reset();

    // Two sources valid from reset: 0 then 2, exact inter-frame spacing.
    cfg_len[0] = 4; cfg_len[2] = 6; set_cfg();
    rdy_pct = 100; stall_pct = 0; strict_gap = 1'b1;
    add_frame(0, 4); add_frame(2, 6);
    plan();
    run("two_src", 400);
    strict_gap = 1'b0;

    // All four sources, length 2, two frames each: order 0,1,2,3,0,...
    do_reset();
    for (int k = 0; k < N; k++) cfg_len[k] = 2;
    set_cfg();
    rdy_pct = 80; stall_pct = 10;
    for (int k = 0; k < N; k++) begin add_frame(k, 2); add_frame(k, 2); end
    plan();
    run("all_rr", 1000);

    // Source tlast earlier than the configured length.
    do_reset();
    cfg_len[1] = 5; set_cfg();
    rdy_pct = 100; stall_pct = 0;
    add_frame(1, 3); add_frame(1, 5);
    plan();
    run("early_last", 400);

    // Source tlast later than the configured length: tail is drained.
    do_reset();
    cfg_len[1] = 3; set_cfg();
    add_frame(1, 6); add_frame(1, 3);
    plan();
    run("drain", 400);

    // Random backpressure and source stalls on a 16-byte frame.
    do_reset();
    cfg_len[0] = 16; set_cfg();
    rdy_pct = 50; stall_pct = 30;
    add_frame(0, 16);
    plan();
    run("backpressure", 600);

    // Random mixes with one zero-length source that must never be served.
    for (int it = 0; it < 3; it++) begin
      do_reset();
      masked = $urandom_range(0, N - 1);
      mcount = 0;
      for (int k = 0; k < N; k++) cfg_len[k] = (k == masked) ? 0 : $urandom_range(1, 8);
      set_cfg();
      rdy_pct = 70; stall_pct = 20;
      for (int k = 0; k < N; k++) begin
        nf = $urandom_range(1, 3);
        for (int f = 0; f < nf; f++) begin
          n = $urandom_range(1, 10);
          add_frame(k, n);
          if (k == masked) mcount += n;
        end
      end
      plan();
      run("random", 3000);
      chk("masked_untouched", 32'(sd[masked].size()), 32'(mcount));
    end

    // Reset in the middle of an 8-beat frame, then source 0 must win again.
    do_reset();
    cfg_len[0] = 8; cfg_len[1] = 3; set_cfg();
    rdy_pct = 100; stall_pct = 0;
    add_frame(0, 8); add_frame(1, 3);
    plan();
    n = 0;
    while (beats < 2 && n < 100) begin step(); n++; end
    chk("midrst_reached_beat2", 32'(beats), 32'd2);
    rst = 1'b1;
    step();
    chk_reset("midrst");
    flush();
    step();
    rst = 1'b0;
    clear_counts();
    cfg_len[0] = 3; cfg_len[1] = 3; set_cfg();
    add_frame(1, 3); add_frame(0, 3);
    plan();
    run("post_rst", 400);

`ifdef PACKET_ARB_TIMEOUT_EN
    // Source stalls after its first beat; an abort beat closes the frame.
    do_reset();
    cfg_len[0] = 4; set_cfg();
    rdy_pct = 100; stall_pct = 0;
    add_frame(0, 4);
    hold[0] = 1'b1;
    mfl[0].delete(); mb[0].delete();
    exp_q.push_back({1'b0, IW'(0), sd[0][0]});
    exp_q.push_back({1'b1, IW'(0), W'(0)});
    exp_to = 1;
    run("timeout", 300);
`endif

    do_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
